tune_sequencer: RTL and testbench
=================================

Name: tune_sequencer

Overview:
Melody controller for the buzzer. It steps through a note table at a fixed tempo and programs a tone divider with each note's half-period. It also handles start/stop/loop requests from the board controls. It sits between the user-control logic and the bz1 pin, replacing hard-wired tone alternation with a sequenced tune.

Parameters:
CLK_HZ, 50000000, reference clock frequency
TEMPO_HZ, 4, beats per second; BEAT_CYC = CLK_HZ/TEMPO_HZ clock cycles per beat
GAP_CYC, 1000, silent articulation cycles between consecutive notes (>=1)
ROM_SEL, 0, note table select: 0 = melody table, 1 = test table
DIV_W, 18, half-period divider width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to begin playback from entry 0
stop  in  1  abort playback; level, sampled every cycle
loop_en  in  1  at end of table restart from entry 0 instead of finishing
busy  out  1  high in LOAD/PLAY/GAP
done  out  1  one-cycle pulse when a tune completes normally
note_idx  out  4  index of current table entry
bz1  out  1  buzzer drive

Behaviour:
- One clock, named clk. Reset is synchronous and active-high, named rst.
- Reset values: state=IDLE, busy=0, done=0, note_idx=0, bz1=0, all counters 0. Reset mid-tune returns to IDLE next edge with no done pulse.
- Table: 16 entries of {div[DIV_W-1:0], dur[3:0]}.
  - div = half-period in cycles; div==0 is a rest (bz1 held 0).
  - dur = beats; dur==0 is the end-of-table marker.
- States:
  - IDLE: start=1 and stop=0 -> LOAD. Set note_idx=0 and busy=1 from the next cycle.
  - LOAD (1 cycle): latch the entry at note_idx and clear the beat and tone counters.
    - If dur==0, apply the end rule.
    - Otherwise -> PLAY.
  - PLAY: stays exactly dur*BEAT_CYC cycles, then -> GAP.
  - GAP: stays exactly GAP_CYC cycles with bz1=0, then applies the end rule if note_idx==15; otherwise note_idx+1 -> LOAD.
  - End rule: if loop_en (sampled at that cycle) -> note_idx=0 -> LOAD. Otherwise -> IDLE with done=1 for exactly one cycle.
- Latency: start sampled at edge N gives LOAD at N+1 and PLAY at N+2.
- Tone: in PLAY, the tone counter counts 0..div-1 and the tone bit toggles on reaching div-1, then the counter wraps to 0.
  - bz1 = tone bit; the tone bit is cleared on LOAD, so each note starts low.
  - First bz1 rise comes div cycles after PLAY entry; period is 2*div.
  - bz1 is forced 0 outside PLAY, and in PLAY when div==0.
- stop=1 in any state -> IDLE next edge: bz1=0, busy=0, no done.
- stop has priority over start; simultaneous start and stop in IDLE stays IDLE.
- start while busy is ignored; playback does not restart.
- done and start in the same cycle: done pulses and a new tune starts (IDLE accepts start on the cycle after done).
- Beat counter width: ceil(log2(BEAT_CYC*15+1)).
- No combinational path from inputs to outputs; all outputs are registered, except bz1, which is gated from registered state.

Decomposition:
- Package tune_pkg holds:
  - state enum {IDLE, LOAD, PLAY, GAP}
  - note_t struct {div, dur}
  - constant arrays MELODY_ROM[16] and TEST_ROM[16]
  - function note_at(rom_sel, idx)
- TEST_ROM contents:
  - entry 0: div=5, dur=1
  - entry 1: div=0, dur=1
  - entry 2: div=2, dur=2
  - entry 3: dur=0
  - rest: dur=0
- One sub-module, tone_divider: inputs clk, rst, clr, en, div; output tone. It implements the half-period counter and toggle.

Test Plan (CLK_HZ=20, TEMPO_HZ=1 so BEAT_CYC=20, GAP_CYC=3, ROM_SEL=1):
- rst, then start pulse at cycle 0 -> busy=1 from cycle 1; PLAY of entry 0 from cycle 2 to 21; bz1 toggles every 5 cycles (rises at 7, falls at 12, ...); bz1=0 during the gap at cycles 22-24.
- Full tune, loop_en=0 -> entry 1 silent for 20 cycles; entry 2 toggles every 2 cycles for 40 cycles; entry 3 terminates; done high exactly one cycle; busy=0; note_idx=3; bz1=0.
- Same as previous with loop_en=1 -> no done pulse; note_idx returns to 0 and the entry 0 waveform repeats with identical timing.
- stop asserted mid-entry 2 -> next cycle busy=0, bz1=0, done never pulses; a later start replays from entry 0.
- start pulses at cycles 5 and 30 during playback, plus start and stop together in IDLE -> the mid-tune starts are ignored (timing unchanged); the simultaneous pair leaves the block in IDLE.
- rst asserted while in PLAY -> next cycle all outputs are at their reset values; the following start behaves as in the first scenario.

Source files
------------

// File: rtl/tune_pkg.sv
// Shared types and note tables for the buzzer tune sequencer.
package tune_pkg;

  localparam int NOTE_DIV_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } state_t;

  typedef struct packed {
    logic [NOTE_DIV_W-1:0] div;
    logic [3:0]            dur;
  } note_t;

  // Half-periods for a 50 MHz clock; dur==0 ends the tune.
  localparam note_t MELODY_ROM [16] = '{
    0:       '{div: 18'd95420, dur: 4'd1},
    1:       '{div: 18'd75758, dur: 4'd1},
    2:       '{div: 18'd63776, dur: 4'd1},
    3:       '{div: 18'd47801, dur: 4'd2},
    4:       '{div: 18'd0,     dur: 4'd1},
    5:       '{div: 18'd63776, dur: 4'd1},
    6:       '{div: 18'd75758, dur: 4'd1},
    7:       '{div: 18'd95420, dur: 4'd2},
    default: '{div: 18'd0,     dur: 4'd0}
  };

  localparam note_t TEST_ROM [16] = '{
    0:       '{div: 18'd5, dur: 4'd1},
    1:       '{div: 18'd0, dur: 4'd1},
    2:       '{div: 18'd2, dur: 4'd2},
    default: '{div: 18'd0, dur: 4'd0}
  };

  function automatic note_t note_at(
    input logic       rom_sel,
    input logic [3:0] idx
  );
    return rom_sel ? TEST_ROM[idx] : MELODY_ROM[idx];
  endfunction

endpackage

// File: rtl/tune_sequencer_tone_divider.sv
// Half-period counter; toggles the tone bit every div enabled cycles.
module tone_divider #(
  parameter int DIV_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tone
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (en) begin
      if (cnt == div - DIV_W'(1)) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/tune_sequencer.sv
// Steps a note table at a fixed tempo and drives the buzzer tone.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TEMPO_HZ = 4,
  parameter int GAP_CYC  = 1000,
  parameter int ROM_SEL  = 0,
  parameter int DIV_W    = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx,
  output logic       bz1
);

  localparam int BEAT_CYC = CLK_HZ / TEMPO_HZ;
  localparam int BW = $clog2(BEAT_CYC * 15 + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t          state, state_n;
  logic [3:0]      idx_n;
  logic            done_n;
  note_t           cur, ent;
  logic [BW-1:0]   beat, beat_n, play_last;
  logic [GW-1:0]   gap, gap_n;
  logic            tone, playing, audible;

  assign ent       = note_at(ROM_SEL != 0, note_idx);
  assign play_last = BW'(cur.dur) * BW'(BEAT_CYC) - BW'(1);
  assign playing   = (state == PLAY);
  assign audible   = playing && (cur.div != '0);
  assign bz1       = tone && audible;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      note_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      beat     <= '0;
      gap      <= '0;
      cur      <= '0;
    end else begin
      state    <= state_n;
      note_idx <= idx_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      beat     <= beat_n;
      gap      <= gap_n;
      if (state == LOAD) cur <= ent;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = note_idx;
    done_n  = 1'b0;
    beat_n  = beat;
    gap_n   = gap;
    if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = LOAD;
            idx_n   = '0;
          end
        end
        LOAD: begin
          beat_n = '0;
          gap_n  = '0;
          if (ent.dur != '0) begin
            state_n = PLAY;
          end else if (loop_en) begin
            idx_n = '0;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        PLAY: begin
          if (beat == play_last) begin
            state_n = GAP;
            gap_n   = '0;
          end else begin
            beat_n = beat + BW'(1);
          end
        end
        GAP: begin
          if (gap != GW'(GAP_CYC - 1)) begin
            gap_n = gap + GW'(1);
          end else if (note_idx != 4'd15) begin
            idx_n   = note_idx + 4'd1;
            state_n = LOAD;
          end else if (loop_en) begin
            idx_n   = '0;
            state_n = LOAD;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  tone_divider #(
    .DIV_W(DIV_W)
  ) u_tone (
    .clk (clk),
    .rst (rst),
    .clr (state == LOAD),
    .en  (audible),
    .div (DIV_W'(cur.div)),
    .tone(tone)
  );

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed checks of tune_sequencer on the short test table.
module tb_tune_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic       busy, done, bz1;
  logic [3:0] note_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic [3:0] idx;
    logic       bz1;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab[$];

  tune_sequencer #(
    .CLK_HZ(20), .TEMPO_HZ(1), .GAP_CYC(3),
    .ROM_SEL(1), .DIV_W(18)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .stop(stop), .loop_en(loop_en),
    .busy(busy), .done(done),
    .note_idx(note_idx), .bz1(bz1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b,
                         input logic d, input logic [3:0] i,
                         input logic z);
    chk({tag, " busy"}, 32'(busy), 32'(b));
    chk({tag, " done"}, 32'(done), 32'(d));
    chk({tag, " idx"}, 32'(note_idx), 32'(i));
    chk({tag, " bz1"}, 32'(bz1), 32'(z));
  endtask

  function automatic vec_t mk(int c, logic b, logic d,
                              int i, logic z);
    vec_t v;
    v.cyc = c; v.busy = b; v.done = d;
    v.idx = 4'(i); v.bz1 = z;
    return v;
  endfunction

  // Start at cycle 0, then walk cycles 1..ncyc checking tab.
  task automatic run_tab(input int ncyc, input int s1,
                         input int s2, input int exp_done);
    int k = 0;
    int dn = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      start = (c == s1) || (c == s2);
      if (done) dn++;
      if (k < tab.size() && tab[k].cyc == c) begin
        chk_all($sformatf("c%0d", c), tab[k].busy,
                tab[k].done, tab[k].idx, tab[k].bz1);
        k++;
      end
      if (c < ncyc) tick();
    end
    start = 1'b0;
    chk("done count", 32'(dn), 32'(exp_done));
  endtask

  initial begin
    int dn, bc;
    tab_a.push_back(mk(1, 1, 0, 0, 0));
    tab_a.push_back(mk(2, 1, 0, 0, 0));
    tab_a.push_back(mk(6, 1, 0, 0, 0));
    tab_a.push_back(mk(7, 1, 0, 0, 1));
    tab_a.push_back(mk(11, 1, 0, 0, 1));
    tab_a.push_back(mk(12, 1, 0, 0, 0));
    tab_a.push_back(mk(17, 1, 0, 0, 1));
    tab_a.push_back(mk(21, 1, 0, 0, 1));
    tab_a.push_back(mk(22, 1, 0, 0, 0));
    tab_a.push_back(mk(24, 1, 0, 0, 0));
    tab_a.push_back(mk(25, 1, 0, 1, 0));
    tab_a.push_back(mk(30, 1, 0, 1, 0));
    tab_a.push_back(mk(45, 1, 0, 1, 0));
    tab_a.push_back(mk(49, 1, 0, 2, 0));
    tab_a.push_back(mk(50, 1, 0, 2, 0));
    tab_a.push_back(mk(51, 1, 0, 2, 0));
    tab_a.push_back(mk(52, 1, 0, 2, 1));
    tab_a.push_back(mk(54, 1, 0, 2, 0));
    tab_a.push_back(mk(89, 1, 0, 2, 1));
    tab_a.push_back(mk(90, 1, 0, 2, 0));
    tab_a.push_back(mk(93, 1, 0, 3, 0));
    tab_a.push_back(mk(94, 0, 1, 3, 0));
    tab_a.push_back(mk(95, 0, 0, 3, 0));
    foreach (tab_a[i])
      if (tab_a[i].cyc <= 93) tab_b.push_back(tab_a[i]);
    tab_b.push_back(mk(94, 1, 0, 0, 0));
    tab_b.push_back(mk(95, 1, 0, 0, 0));
    tab_b.push_back(mk(99, 1, 0, 0, 0));
    tab_b.push_back(mk(100, 1, 0, 0, 1));
    tab_b.push_back(mk(105, 1, 0, 0, 0));
    tab_b.push_back(mk(110, 1, 0, 0, 1));

    tick();
    tick();
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0);

    // Full tune, no loop.
    tab = tab_a;
    run_tab(96, -1, -1, 1);

    // Looping tune, then stop.
    loop_en = 1'b1;
    tab = tab_b;
    run_tab(111, -1, -1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    chk_all("loop stop", 0, 0, 0, 0);

    // Stop in the middle of entry 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (59) tick();
    chk("c60 bz1 before stop", 32'(bz1), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("after stop", 0, 0, 2, 0);
    dn = 0;
    bc = 0;
    repeat (40) begin
      tick();
      if (done) dn++;
      if (busy) bc++;
    end
    chk("stop done count", 32'(dn), 32'd0);
    chk("stop busy count", 32'(bc), 32'd0);

    // Restart with ignored mid-tune starts; start on done.
    tab = tab_a;
    run_tab(94, 5, 30, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart on done", 1, 0, 0, 0);
    repeat (5) tick();
    chk_all("restart c100", 1, 0, 0, 0);
    tick();
    chk_all("restart c101", 1, 0, 0, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("stop 2", 0, 0, 0, 0);

    // Simultaneous start and stop in idle.
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start+stop busy", 32'(busy), 32'd0);
    tick();
    chk("start+stop busy2", 32'(busy), 32'd0);
    chk("start+stop done", 32'(done), 32'd0);

    // Reset in PLAY.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("c10 bz1 before rst", 32'(bz1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst in play", 0, 0, 0, 0);
    tick();
    chk_all("rst idle", 0, 0, 0, 0);
    run_tab(24, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
